multicycle_alu: RTL and testbench
=================================

Name: multicycle_alu

Overview:
Parametrised-width successor to the single-cycle datapath ALU. Adds an iterative multiply/divide engine with HI/LO registers and a start/done handshake. Sits in the EX stage of the multi-cycle CPU; the controller holds the stage while busy=1.

Parameters:
WIDTH, 32, operand/result width; even, >=8
SHW, $clog2(WIDTH), shift-amount width; derived localparam, not overridable

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
start  in  1  operation request; sampled only when busy=0
ALUConf  in  5  operation code, sampled with start
Sign  in  1  signed SLT/MULT/DIV when 1, sampled with start
In1  in  WIDTH  operand A (shift amount in In1[SHW-1:0])
In2  in  WIDTH  operand B
busy  out  1  engine occupied; start ignored
done  out  1  one-cycle pulse, Result/Hi/Lo valid
Result  out  WIDTH  registered result, held until next accepted op
Zero  out  1  registered (Result==0)
Hi  out  WIDTH  HI register
Lo  out  WIDTH  LO register

Behaviour:
- Reset: state IDLE; busy=0, done=0, Result=0, Zero=1, Hi=0, Lo=0. Reset in any state aborts the operation, with no done pulse.
- FSM states: IDLE, EXEC, FIX, DONE. start is accepted in IDLE or DONE (back-to-back allowed).
- Single-cycle ops (00000 ADD, 00001 OR, 00010 AND, 00110 SUB, 00111 SLT, 01100 NOR, 01101 XOR, 10000 SRL, 11000 SRA, 11001 SLL, 11010 ANDN, 01000 MFHI, 01001 MFLO):
  - On the accept edge, Result is loaded and the state goes to DONE.
  - done=1 in the following cycle (latency 1). busy is never asserted.
- Arithmetic rules:
  - Add/sub wrap modulo 2^WIDTH.
  - SLT is a true two's-complement compare when Sign=1, unsigned compare when Sign=0. Result is zero-extended 0/1.
  - SRA sign-fills from In2[WIDTH-1].
  - Unknown codes give Result=0.
- MULT (00011) and DIV (00100):
  - Accept edge: latch operand magnitudes (abs when Sign=1) and result signs, then go to EXEC with busy=1.
  - EXEC: exactly WIDTH cycles. Radix-2 shift-add for MULT, restoring shift-subtract for DIV. Iteration counter runs 0..WIDTH-1.
  - FIX: one cycle of sign correction, then write Hi/Lo and Result=Lo.
  - DONE: done=1, busy=0.
  - Latency from accept edge to done is WIDTH+2 cycles (34 at WIDTH=32).
- MULT: {Hi,Lo} = full 2*WIDTH product.
- DIV: Lo = quotient truncated toward zero; Hi = remainder with the sign of the dividend.
- DIV boundary cases:
  - Signed MIN / -1: Lo=MIN, Hi=0.
  - Divide by zero: Lo = all ones, Hi = In1. Full latency still applies.
- start while busy=1 is dropped with no queueing. Inputs need not be held after the accept edge.
- Hi/Lo change only at FIX of MULT/DIV, or at reset.
- Zero updates in the same cycle as Result.

Optional Feature:
- Macro ALU_MULDIV_EN.
- Defined: MULT/DIV engine, Hi/Lo registers, and MFHI/MFLO are present as above.
- Undefined:
  - Engine and Hi/Lo registers are removed; Hi and Lo are tied to 0.
  - MULT, DIV, MFHI and MFLO behave as unknown codes: 1-cycle latency, Result=0.
  - busy is constant 0.

Decomposition:
- Package alu_pkg holds ALUConf code localparams (all 15 names), the FSM state typedef (IDLE/EXEC/FIX/DONE), and the divide-by-zero quotient constant.
- One sub-module, muldiv_iter, contains the iteration counter, partial-product/remainder datapath and sign fix. It has a start/last handshake to the parent FSM and outputs hi/lo.
- The parent keeps the single-cycle op mux and the FSM.

Test Plan:
- ADD 0x7FFFFFFF + 1, start pulse → done 1 cycle later, Result=0x80000000, Zero=0; SUB 5-5 → Result=0, Zero=1.
- SLT signed In1=0xFFFFFFFF, In2=1 → Result=1. Same operands unsigned → Result=0. SRA In2=0x80000000, shamt 4 → 0xF8000000.
- MULT signed -3 × 7 → done exactly 34 cycles after accept, Hi=0xFFFFFFFF, Lo=0xFFFFFFEB. Unsigned 0xFFFFFFFF² → Hi=0xFFFFFFFE, Lo=1.
- DIV signed -7 / 2 → Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. 0x80000000 / -1 → Lo=0x80000000, Hi=0. Divide by zero of 9 → Lo=0xFFFFFFFF, Hi=9.
- Start MULT; pulse start with ADD at cycle 10 → ADD ignored, busy stays 1. Then MFHI/MFLO back-to-back from DONE → correct values on consecutive done pulses.
- Assert reset at cycle 15 of a DIV → next cycle busy=0, done=0, Hi=Lo=0, Result=0; no done pulse afterwards. Repeat with ALU_MULDIV_EN undefined: MULT gives 1-cycle done, Result=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for multicycle_alu and its multiply/divide engine.
// Contents:
//   OP_*        ALUConf operation codes (5 bits)
//   state_t     controller FSM states IDLE/EXEC/FIX/DONE
//   DIVZ_Q_BIT  fill bit for the quotient of a divide by zero
// The engine itself is only built when ALU_MULDIV_EN is defined.
package alu_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_OR   = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_MULT = 5'b00011;
  localparam logic [4:0] OP_DIV  = 5'b00100;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SLT  = 5'b00111;
  localparam logic [4:0] OP_MFHI = 5'b01000;
  localparam logic [4:0] OP_MFLO = 5'b01001;
  localparam logic [4:0] OP_NOR  = 5'b01100;
  localparam logic [4:0] OP_XOR  = 5'b01101;
  localparam logic [4:0] OP_SRL  = 5'b10000;
  localparam logic [4:0] OP_SRA  = 5'b11000;
  localparam logic [4:0] OP_SLL  = 5'b11001;
  localparam logic [4:0] OP_ANDN = 5'b11010;

  typedef enum logic [1:0] {IDLE, EXEC, FIX, DONE} state_t;

  // Divide by zero returns an all-ones quotient.
  localparam logic DIVZ_Q_BIT = 1'b1;

endpackage

// File: rtl/multicycle_alu_muldiv_iter.sv
// muldiv_iter: iterative radix-2 multiply / restoring divide engine.
// Ports:
//   clk          clock, rising edge
//   load         capture operands and clear the iteration counter
//   step         perform one iteration (parent is in EXEC)
//   is_div, sign operation select and signed mode, sampled with load
//   a, b         operands (multiplier/dividend, multiplicand/divisor)
//   last         high during the final iteration cycle
//   hi, lo       sign-corrected result, valid in the cycle after last
// Instantiated by multicycle_alu when ALU_MULDIV_EN is defined.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, mcand, a_raw;
  logic [WIDTH-1:0] nxt_hi, nxt_lo;
  logic [WIDTH:0]   sum, trial;
  logic [2*WIDTH-1:0] prod;
  logic             div_op, neg_q, neg_r, divz;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic s);
    return (s && x[WIDTH-1]) ? -x : x;
  endfunction

  // acc_hi is the running product high half (MULT) or partial remainder (DIV);
  // acc_lo holds the multiplier or dividend and fills with product/quotient bits.
  always_comb begin
    sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? mcand : {WIDTH{1'b0}})};
    trial = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, mcand};
    if (div_op) begin
      if (!trial[WIDTH]) begin
        nxt_hi = trial[WIDTH-1:0];
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        nxt_hi = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      {nxt_hi, nxt_lo} = {sum, acc_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      cnt    <= '0;
      div_op <= is_div;
      acc_hi <= '0;
      acc_lo <= mag(a, sign);
      mcand  <= mag(b, sign);
      a_raw  <= a;
      neg_q  <= sign && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r  <= sign && a[WIDTH-1];
      divz   <= (b == '0);
    end else if (step) begin
      cnt    <= cnt + 1'b1;
      acc_hi <= nxt_hi;
      acc_lo <= nxt_lo;
    end
  end

  assign last = step && (cnt == CNT_LAST);

  // Sign correction applied on magnitudes; MIN / -1 falls out naturally
  // since |MIN| / 1 = MIN as an unsigned pattern and the quotient sign is +.
  always_comb begin
    prod = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    if (div_op) begin
      if (divz) begin
        lo = {WIDTH{DIVZ_Q_BIT}};
        hi = a_raw;
      end else begin
        lo = neg_q ? -acc_lo : acc_lo;
        hi = neg_r ? -acc_hi : acc_hi;
      end
    end else begin
      {hi, lo} = prod;
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// multicycle_alu: EX-stage ALU with optional iterative MULT/DIV engine.
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   start, ALUConf, Sign operation request, code and signed mode
//   In1, In2             operands (shift amount in In1[SHW-1:0])
//   busy                 engine occupied, start ignored
//   done                 one-cycle pulse when Result/Hi/Lo are valid
//   Result, Zero         registered result and Result==0 flag
//   Hi, Lo               HI/LO registers
// Define ALU_MULDIV_EN to build the MULT/DIV engine, Hi/Lo and MFHI/MFLO.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       ALUConf,
  input  logic             Sign,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int SHW = $clog2(WIDTH);

  state_t           state;
  logic             accept, slt_bit;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_y;

  assign accept  = start && (state == IDLE || state == DONE);
  assign shamt   = In1[SHW-1:0];
  assign slt_bit = Sign ? ($signed(In1) < $signed(In2)) : (In1 < In2);

`ifdef ALU_MULDIV_EN
  logic             md_op, md_last, busy_q;
  logic [WIDTH-1:0] md_hi, md_lo, hi_q, lo_q;

  assign md_op = (ALUConf == OP_MULT) || (ALUConf == OP_DIV);

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .load   (accept && md_op),
    .step   (state == EXEC),
    .is_div (ALUConf == OP_DIV),
    .sign   (Sign),
    .a      (In1),
    .b      (In2),
    .last   (md_last),
    .hi     (md_hi),
    .lo     (md_lo)
  );

  assign busy = busy_q;
  assign Hi   = hi_q;
  assign Lo   = lo_q;
`else
  assign busy = 1'b0;
  assign Hi   = '0;
  assign Lo   = '0;
`endif

  always_comb begin
    alu_y = '0;
    case (ALUConf)
      OP_ADD:  alu_y = In1 + In2;
      OP_OR:   alu_y = In1 | In2;
      OP_AND:  alu_y = In1 & In2;
      OP_SUB:  alu_y = In1 - In2;
      OP_SLT:  alu_y = {{(WIDTH-1){1'b0}}, slt_bit};
      OP_NOR:  alu_y = ~(In1 | In2);
      OP_XOR:  alu_y = In1 ^ In2;
      OP_SRL:  alu_y = In2 >> shamt;
      OP_SRA:  alu_y = $signed(In2) >>> shamt;
      OP_SLL:  alu_y = In2 << shamt;
      OP_ANDN: alu_y = In1 & ~In2;
`ifdef ALU_MULDIV_EN
      OP_MFHI: alu_y = hi_q;
      OP_MFLO: alu_y = lo_q;
`endif
      default: alu_y = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      done   <= 1'b0;
      Result <= '0;
      Zero   <= 1'b1;
`ifdef ALU_MULDIV_EN
      busy_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done  <= 1'b0;
          state <= IDLE;
          if (accept) begin
`ifdef ALU_MULDIV_EN
            if (md_op) begin
              state  <= EXEC;
              busy_q <= 1'b1;
            end else begin
              Result <= alu_y;
              Zero   <= (alu_y == '0);
              state  <= DONE;
              done   <= 1'b1;
            end
`else
            Result <= alu_y;
            Zero   <= (alu_y == '0);
            state  <= DONE;
            done   <= 1'b1;
`endif
          end
        end
`ifdef ALU_MULDIV_EN
        EXEC: if (md_last) state <= FIX;
        FIX: begin
          hi_q   <= md_hi;
          lo_q   <= md_lo;
          Result <= md_lo;
          Zero   <= (md_lo == '0);
          busy_q <= 1'b0;
          done   <= 1'b1;
          state  <= DONE;
        end
`endif
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed testbench for multicycle_alu (WIDTH=32). Expectations follow the
// build: with ALU_MULDIV_EN the engine results are checked, without it the
// MULT/DIV/MFHI/MFLO codes are checked as unknown 1-cycle ops.
module tb_multicycle_alu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, Sign;
  logic [4:0]  ALUConf;
  logic [31:0] In1, In2;
  logic        busy, done, Zero;
  logic [31:0] Result, Hi, Lo;

  int checks = 0;
  int failures = 0;
  int lat;
  int done_seen;
  logic bsy1;

  multicycle_alu #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .ALUConf(ALUConf), .Sign(Sign),
    .In1(In1), .In2(In2), .busy(busy), .done(done), .Result(Result),
    .Zero(Zero), .Hi(Hi), .Lo(Lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op, scramble inputs after the accept edge, and return the
  // done latency counted in cycles after the accept edge (accept cycle = 1).
  task automatic run_op(input logic [4:0] conf, input logic s, input logic [31:0] a,
                        input logic [31:0] b, output int l, output logic b1);
    @(negedge clk);
    start = 1'b1; ALUConf = conf; Sign = s; In1 = a; In2 = b;
    @(posedge clk); #1;
    start = 1'b0; Sign = ~s; In1 = 32'hA5A5_5A5A; In2 = 32'h5A5A_A5A5;
    l = 1; b1 = busy;
    while (!done && l < 100) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; Sign = 1'b0; ALUConf = OP_ADD; In1 = '0; In2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_result", Result, 32'd0);
    chk("rst_zero", {31'b0, Zero}, 32'd1);
    chk("rst_hi", Hi, 32'd0);
    chk("rst_lo", Lo, 32'd0);
    @(negedge clk); reset = 1'b0;

    run_op(OP_ADD, 1'b0, 32'h7FFF_FFFF, 32'h1, lat, bsy1);
    chk("add_lat", lat, 32'd1);
    chk("add_busy", {31'b0, bsy1}, 32'd0);
    chk("add_res", Result, 32'h8000_0000);
    chk("add_zero", {31'b0, Zero}, 32'd0);
    @(posedge clk); #1;
    chk("done_pulse_end", {31'b0, done}, 32'd0);

    run_op(OP_SUB, 1'b0, 32'd5, 32'd5, lat, bsy1);
    chk("sub_res", Result, 32'd0);
    chk("sub_zero", {31'b0, Zero}, 32'd1);
    run_op(OP_SLT, 1'b1, 32'hFFFF_FFFF, 32'h1, lat, bsy1);
    chk("slt_s", Result, 32'd1);
    run_op(OP_SLT, 1'b0, 32'hFFFF_FFFF, 32'h1, lat, bsy1);
    chk("slt_u", Result, 32'd0);
    run_op(OP_SRA, 1'b0, 32'd4, 32'h8000_0000, lat, bsy1);
    chk("sra", Result, 32'hF800_0000);
    run_op(OP_SRL, 1'b0, 32'd4, 32'h8000_0000, lat, bsy1);
    chk("srl", Result, 32'h0800_0000);
    run_op(OP_SLL, 1'b0, 32'd4, 32'h0000_000F, lat, bsy1);
    chk("sll", Result, 32'h0000_00F0);
    run_op(OP_NOR, 1'b0, 32'h0F0F_0F0F, 32'h00FF_00FF, lat, bsy1);
    chk("nor", Result, 32'hF000_F000);
    run_op(OP_XOR, 1'b0, 32'h0F0F_0F0F, 32'h00FF_00FF, lat, bsy1);
    chk("xor", Result, 32'h0FF0_0FF0);
    run_op(OP_ANDN, 1'b0, 32'h0F0F_0F0F, 32'h00FF_00FF, lat, bsy1);
    chk("andn", Result, 32'h0F00_0F00);
    run_op(OP_OR, 1'b0, 32'h0F0F_0F0F, 32'h00FF_00FF, lat, bsy1);
    chk("or", Result, 32'h0FFF_0FFF);
    run_op(OP_AND, 1'b0, 32'h0F0F_0F0F, 32'h00FF_00FF, lat, bsy1);
    chk("and", Result, 32'h000F_000F);
    run_op(5'b11111, 1'b0, 32'h1234, 32'h5678, lat, bsy1);
    chk("unknown_res", Result, 32'd0);
    chk("unknown_zero", {31'b0, Zero}, 32'd1);

`ifdef ALU_MULDIV_EN
    run_op(OP_MULT, 1'b1, 32'hFFFF_FFFD, 32'd7, lat, bsy1);
    chk("mult_s_lat", lat, 32'd34);
    chk("mult_s_busy", {31'b0, bsy1}, 32'd1);
    chk("mult_s_busy_done", {31'b0, busy}, 32'd0);
    chk("mult_s_hi", Hi, 32'hFFFF_FFFF);
    chk("mult_s_lo", Lo, 32'hFFFF_FFEB);
    chk("mult_s_res", Result, 32'hFFFF_FFEB);
    run_op(OP_MULT, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bsy1);
    chk("mult_u_hi", Hi, 32'hFFFF_FFFE);
    chk("mult_u_lo", Lo, 32'h0000_0001);
    run_op(OP_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2, lat, bsy1);
    chk("div_s_lat", lat, 32'd34);
    chk("div_s_lo", Lo, 32'hFFFF_FFFD);
    chk("div_s_hi", Hi, 32'hFFFF_FFFF);
    run_op(OP_DIV, 1'b0, 32'd100, 32'd7, lat, bsy1);
    chk("div_u_lo", Lo, 32'd14);
    chk("div_u_hi", Hi, 32'd2);
    run_op(OP_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, bsy1);
    chk("div_ovf_lo", Lo, 32'h8000_0000);
    chk("div_ovf_hi", Hi, 32'd0);
    run_op(OP_DIV, 1'b1, 32'd9, 32'd0, lat, bsy1);
    chk("div0_lat", lat, 32'd34);
    chk("div0_lo", Lo, 32'hFFFF_FFFF);
    chk("div0_hi", Hi, 32'd9);

    // MULT with an ADD request dropped while busy.
    @(negedge clk);
    start = 1'b1; ALUConf = OP_MULT; Sign = 1'b0; In1 = 32'h0001_0000; In2 = 32'h0003_0005;
    @(posedge clk); #1;
    start = 1'b0; lat = 1;
    repeat (9) begin @(posedge clk); #1; lat++; end
    @(negedge clk);
    start = 1'b1; ALUConf = OP_ADD; In1 = 32'd1; In2 = 32'd1;
    @(posedge clk); #1;
    start = 1'b0; lat++;
    chk("drop_busy", {31'b0, busy}, 32'd1);
    chk("drop_done", {31'b0, done}, 32'd0);
    while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("drop_lat", lat, 32'd34);
    chk("drop_hi", Hi, 32'h0000_0003);
    chk("drop_res", Result, 32'h0005_0000);
    run_op(OP_MFHI, 1'b0, 32'd0, 32'd0, lat, bsy1);
    chk("mfhi_lat", lat, 32'd1);
    chk("mfhi_res", Result, 32'h0000_0003);
    run_op(OP_MFLO, 1'b0, 32'd0, 32'd0, lat, bsy1);
    chk("mflo_lat", lat, 32'd1);
    chk("mflo_res", Result, 32'h0005_0000);
`else
    run_op(OP_ADD, 1'b0, 32'd1, 32'd2, lat, bsy1);
    chk("pre_add", Result, 32'd3);
    run_op(OP_MULT, 1'b1, 32'hFFFF_FFFD, 32'd7, lat, bsy1);
    chk("nomd_mult_lat", lat, 32'd1);
    chk("nomd_mult_busy", {31'b0, bsy1}, 32'd0);
    chk("nomd_mult_res", Result, 32'd0);
    chk("nomd_mult_zero", {31'b0, Zero}, 32'd1);
    run_op(OP_ADD, 1'b0, 32'd4, 32'd4, lat, bsy1);
    run_op(OP_DIV, 1'b0, 32'd100, 32'd7, lat, bsy1);
    chk("nomd_div_lat", lat, 32'd1);
    chk("nomd_div_res", Result, 32'd0);
    run_op(OP_ADD, 1'b0, 32'd4, 32'd4, lat, bsy1);
    run_op(OP_MFLO, 1'b0, 32'd0, 32'd0, lat, bsy1);
    chk("nomd_mflo_res", Result, 32'd0);
    chk("nomd_hi", Hi, 32'd0);
    chk("nomd_lo", Lo, 32'd0);
`endif

    // Reset in the middle of a DIV (accept edge = cycle 1, reset at cycle 15).
    run_op(OP_ADD, 1'b0, 32'd1, 32'd1, lat, bsy1);
    chk("prereset_res", Result, 32'd2);
    @(negedge clk);
    start = 1'b1; ALUConf = OP_DIV; Sign = 1'b0; In1 = 32'd100; In2 = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (13) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_res", Result, 32'd0);
    chk("abort_zero", {31'b0, Zero}, 32'd1);
    chk("abort_hi", Hi, 32'd0);
    chk("abort_lo", Lo, 32'd0);
    @(negedge clk); reset = 1'b0;
    done_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    chk("abort_no_done", done_seen, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
